// File: rtl/sr_pkg.sv
// sr_pkg: status register op encoding shared by the status_reg_stack files
package sr_pkg;
  typedef logic [2:0] sr_op_t;
  localparam sr_op_t SR_NOP   = 3'd0;
  localparam sr_op_t SR_LOAD  = 3'd1;
  localparam sr_op_t SR_SET   = 3'd2;
  localparam sr_op_t SR_CLR   = 3'd3;
  localparam sr_op_t SR_FLAGS = 3'd4;
endpackage

// File: rtl/status_reg_stack_if.sv
// status_reg_stack_if: op/flag/stack control inputs and status outputs of the status register
interface status_reg_stack_if
  import sr_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);
  localparam int LW = $clog2(DEPTH + 1);
  sr_op_t           sr_op;
  logic [WIDTH-1:0] sr_set;
  logic [WIDTH-1:0] flag_in;
  logic [WIDTH-1:0] flag_mask;
  logic             push;
  logic             pop;
  logic [WIDTH-1:0] sr_data;
  logic [LW-1:0]    level;
  logic             full;
  logic             empty;
  logic             ovf;
  logic             unf;
  modport master (
    output sr_op, sr_set, flag_in, flag_mask, push, pop,
    input  sr_data, level, full, empty, ovf, unf
  );
  modport slave (
    input  sr_op, sr_set, flag_in, flag_mask, push, pop,
    output sr_data, level, full, empty, ovf, unf
  );
endinterface

// File: rtl/status_reg_stack_lifo.sv
// sr_lifo: save stack for the status word with level tracking and sticky overflow/underflow flags
module sr_lifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int LW = $clog2(DEPTH + 1),
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] top,
  output logic [LW-1:0]    level,
  output logic             full,
  output logic             empty,
  output logic             ovf,
  output logic             unf,
  output logic             pop_ok
);
  logic [WIDTH-1:0] stack_q [2**AW];
  logic [WIDTH-1:0] stack_d [2**AW];
  logic [LW-1:0]    level_q, level_d;
  logic             ovf_q, ovf_d, unf_q, unf_d, push_ok;
  // push and pop in the same cycle cancel and flag both errors; reset overrides everything
  always_comb begin
    full    = level_q == LW'(DEPTH);
    empty   = level_q == '0;
    push_ok = push & ~pop & ~full & ~rst;
    pop_ok  = pop & ~push & ~empty & ~rst;
    stack_d = stack_q;
    if (push_ok) stack_d[level_q[AW-1:0]] = din;
    level_d = rst ? '0 : push_ok ? level_q + LW'(1) : pop_ok ? level_q - LW'(1) : level_q;
    ovf_d   = ~rst & (ovf_q | (push & (pop | full)));
    unf_d   = ~rst & (unf_q | (pop & (push | empty)));
    top     = stack_q[AW'(level_q - LW'(1))];
  end
  // stack contents are deliberately left unreset
  always_ff @(posedge clk) begin
    stack_q <= stack_d;
    level_q <= level_d;
    ovf_q   <= ovf_d;
    unf_q   <= unf_d;
  end
  assign level = level_q;
  assign ovf   = ovf_q;
  assign unf   = unf_q;
endmodule

// File: rtl/status_reg_stack.sv
// status_reg_stack: registered status word with bit ops, sticky flag merge and interrupt save stack
module status_reg_stack
  import sr_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter int               DEPTH       = 4,
  parameter logic [WIDTH-1:0] RESET_VAL   = '0,
  parameter logic [WIDTH-1:0] STICKY_MASK = '0
) (
  input logic               clk,
  input logic               rst,
  status_reg_stack_if.slave bus
);
  logic [WIDTH-1:0] sr_data_q, sr_data_d, nxt, upd, top;
  logic             restore;
  sr_lifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_lifo (
    .clk    (clk),
    .rst    (rst),
    .push   (bus.push),
    .pop    (bus.pop),
    .din    (sr_data_q),
    .top    (top),
    .level  (bus.level),
    .full   (bus.full),
    .empty  (bus.empty),
    .ovf    (bus.ovf),
    .unf    (bus.unf),
    .pop_ok (restore)
  );
  // next word from the op; a successful pop restores the saved word instead
  always_comb begin
    upd       = bus.flag_in & bus.flag_mask;
    nxt       = bus.sr_op == SR_LOAD  ? bus.sr_set :
                bus.sr_op == SR_SET   ? sr_data_q | bus.sr_set :
                bus.sr_op == SR_CLR   ? sr_data_q & ~bus.sr_set :
                bus.sr_op == SR_FLAGS ? (((sr_data_q & ~bus.flag_mask) | upd) & ~STICKY_MASK) |
                                        ((sr_data_q | upd) & STICKY_MASK) :
                sr_data_q;
    sr_data_d = rst ? RESET_VAL : restore ? top : nxt;
  end
  // status word register
  always_ff @(posedge clk) sr_data_q <= sr_data_d;
  assign bus.sr_data = sr_data_q;
endmodule
